drum_step_sequencer: RTL and testbench

- Pattern-driven trigger generator for the one-shot drum voices (kick, snare, hihat, ...). It drives each voice's trig input.
- Holds one NUM_STEPS-bit pattern per voice, advances a step counter at a programmable tempo, and emits a fixed-length trigger pulse on every voice whose pattern bit is set at the current step.
- Runs on the master clock (256x sample rate), alongside the oneshot sources.

---
 rtl/drum_step_sequencer.sv | 178 +++++++++++++++++
 tb/tb_drum_step_sequencer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/drum_step_sequencer.sv
// drum_step_sequencer: pattern-driven trigger generator for the one-shot drum voices.
// Each voice has a NUM_STEPS-bit pattern. A step counter advances once per step
// interval. Every voice whose bit is set at the new step gets a TRIG_LEN-cycle pulse.
// Optional feature macro: DRUM_SEQ_SWING_EN adds a swing input. That input lengthens
// even->odd intervals and shortens odd->even intervals by the same amount.
module drum_step_sequencer #(
   parameter int unsigned NUM_VOICES  = 4,
   parameter int unsigned NUM_STEPS   = 16,
   parameter int unsigned PERIOD_BITS = 24,
   parameter int unsigned TRIG_LEN    = 256,
   localparam int unsigned VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1,
   localparam int unsigned SW = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   run,
   input  logic [PERIOD_BITS-1:0] step_period,
`ifdef DRUM_SEQ_SWING_EN
   input  logic [PERIOD_BITS-1:0] swing,
`endif
   input  logic                   pat_wr_en,
   input  logic [VW-1:0]          pat_wr_voice,
   input  logic [NUM_STEPS-1:0]   pat_wr_data,
   output logic [NUM_VOICES-1:0]  trig_out,
   output logic [SW-1:0]          step_idx,
   output logic                   step_strobe
);

   // One extra bit so eff_period + swing can never overflow.
   localparam int unsigned IW = PERIOD_BITS + 1;
   localparam int unsigned LW = (TRIG_LEN > 1) ? $clog2(TRIG_LEN) : 1;
   localparam logic [IW-1:0] MinPeriod = IW'(2 * TRIG_LEN);
   localparam logic [SW-1:0] LastStep  = SW'(NUM_STEPS - 1);

   typedef enum logic [0:0] {StIdle, StPlay} state_e;

   state_e                 state_q, state_d;
   logic [IW-1:0]          tick_q, tick_d;
   logic [IW-1:0]          interval_q, interval_d;
   logic [SW-1:0]          step_q, step_d;
   logic [NUM_VOICES-1:0]  trig_q, trig_d;
   logic                   strobe_q, strobe_d;
   logic [LW-1:0]          pulse_q, pulse_d;
   logic [NUM_STEPS-1:0]   pat_q [NUM_VOICES];

   logic                   fire;
   logic [SW-1:0]          fire_step;
   logic [IW-1:0]          eff_period;

   // Clamp keeps every trigger low for at least TRIG_LEN cycles before the next one.
   assign eff_period = ({1'b0, step_period} > MinPeriod) ? {1'b0, step_period} : MinPeriod;

`ifdef DRUM_SEQ_SWING_EN
   logic [IW-1:0] swing_c_q, swing_c_d;
   logic [IW-1:0] swing_room, swing_lim, swing_odd;

   // Swing is bounded so that the short interval never drops below the clamp.
   always_comb begin
      swing_room = eff_period - MinPeriod;
      swing_lim  = ({1'b0, swing} < swing_room) ? {1'b0, swing} : swing_room;
      swing_odd  = (swing_c_q < swing_room) ? swing_c_q : swing_room;
   end
`endif

   // Next-state logic: step timing, pulse shaping and run/stop control.
   always_comb begin
      state_d    = state_q;
      tick_d     = tick_q;
      interval_d = interval_q;
      step_d     = step_q;
      trig_d     = trig_q;
      strobe_d   = 1'b0;
      pulse_d    = pulse_q;
      fire       = 1'b0;
      fire_step  = '0;
`ifdef DRUM_SEQ_SWING_EN
      swing_c_d  = swing_c_q;
`endif

      // The pulse counter holds the remaining high cycles minus one.
      if (pulse_q != '0) begin
         pulse_d = pulse_q - LW'(1);
      end else begin
         trig_d = '0;
      end

      unique case (state_q)
         StIdle: begin
            trig_d  = '0;
            step_d  = '0;
            tick_d  = '0;
            pulse_d = '0;
            if (run) begin
               state_d = StPlay;
               fire    = 1'b1;
            end
         end
         StPlay: begin
            if (!run) begin
               state_d = StIdle;
               trig_d  = '0;
               step_d  = '0;
               tick_d  = '0;
               pulse_d = '0;
            end else if (tick_q == interval_q - IW'(1)) begin
               fire      = 1'b1;
               fire_step = (step_q == LastStep) ? '0 : step_q + SW'(1);
            end else begin
               tick_d = tick_q + IW'(1);
            end
         end
         default: state_d = StIdle;
      endcase

      if (fire) begin
         step_d   = fire_step;
         tick_d   = '0;
         strobe_d = 1'b1;
         pulse_d  = LW'(TRIG_LEN - 1);
         for (int v = 0; v < NUM_VOICES; v++) begin
            trig_d[v] = pat_q[v][fire_step];
         end
`ifdef DRUM_SEQ_SWING_EN
         if (!fire_step[0]) begin
            swing_c_d  = swing_lim;
            interval_d = eff_period + swing_lim;
         end else begin
            interval_d = eff_period - swing_odd;
         end
`else
         interval_d = eff_period;
`endif
      end
   end

   // Sequencer state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         tick_q     <= '0;
         interval_q <= '0;
         step_q     <= '0;
         trig_q     <= '0;
         strobe_q   <= 1'b0;
         pulse_q    <= '0;
`ifdef DRUM_SEQ_SWING_EN
         swing_c_q  <= '0;
`endif
      end else begin
         state_q    <= state_d;
         tick_q     <= tick_d;
         interval_q <= interval_d;
         step_q     <= step_d;
         trig_q     <= trig_d;
         strobe_q   <= strobe_d;
         pulse_q    <= pulse_d;
`ifdef DRUM_SEQ_SWING_EN
         swing_c_q  <= swing_c_d;
`endif
      end
   end

   // Pattern storage. A fire on the same edge reads the old value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int v = 0; v < NUM_VOICES; v++) begin
            pat_q[v] <= '0;
         end
      end else if (pat_wr_en && (32'(pat_wr_voice) < NUM_VOICES)) begin
         pat_q[pat_wr_voice] <= pat_wr_data;
      end
   end

   assign trig_out    = trig_q;
   assign step_idx    = step_q;
   assign step_strobe = strobe_q;

endmodule

// File: tb/tb_drum_step_sequencer.sv
// Directed self-checking bench for drum_step_sequencer (TRIG_LEN=4, 16 steps, 4 voices).
module tb_drum_step_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        run;
   logic [23:0] step_period;
`ifdef DRUM_SEQ_SWING_EN
   logic [23:0] swing;
`endif
   logic        pat_wr_en;
   logic [1:0]  pat_wr_voice;
   logic [15:0] pat_wr_data;
   logic [3:0]  trig_out;
   logic [3:0]  step_idx;
   logic        step_strobe;

   int          n_checks = 0;
   int          n_fail = 0;
   int          cyc = 0;
   logic [15:0] pat_m [4];

   drum_step_sequencer #(
      .NUM_VOICES (4),
      .NUM_STEPS  (16),
      .PERIOD_BITS(24),
      .TRIG_LEN   (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .run         (run),
      .step_period (step_period),
`ifdef DRUM_SEQ_SWING_EN
      .swing       (swing),
`endif
      .pat_wr_en   (pat_wr_en),
      .pat_wr_voice(pat_wr_voice),
      .pat_wr_data (pat_wr_data),
      .trig_out    (trig_out),
      .step_idx    (step_idx),
      .step_strobe (step_strobe)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Advance until a strobe is seen (bounded); returns its cycle stamp.
   task automatic wait_strobe(input string tag, output int at);
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while (!step_strobe && n < 400);
      check(tag, 32'(step_strobe), 32'd1);
      at = cyc;
   endtask

   task automatic write_pat(input logic [1:0] v, input logic [15:0] d);
      pat_wr_en    = 1'b1;
      pat_wr_voice = v;
      pat_wr_data  = d;
      tick();
      pat_wr_en    = 1'b0;
      pat_m[v]     = d;
   endtask

   function automatic logic [3:0] exp_trig(input int s);
      logic [3:0] e;
      for (int v = 0; v < 4; v++) e[v] = pat_m[v][s];
      return e;
   endfunction

   initial begin
      int prev, at, t0, k;
      logic [3:0] e;
      rst          = 1'b1;
      run          = 1'b0;
      step_period  = 24'd20;
`ifdef DRUM_SEQ_SWING_EN
      swing        = '0;
`endif
      pat_wr_en    = 1'b0;
      pat_wr_voice = '0;
      pat_wr_data  = '0;
      for (int v = 0; v < 4; v++) pat_m[v] = '0;

      repeat (3) tick();
      check("rst_trig", 32'(trig_out), 32'd0);
      check("rst_step", 32'(step_idx), 32'd0);
      check("rst_strobe", 32'(step_strobe), 32'd0);
      rst = 1'b0;
      tick();

      // Basic loop at period 20
      write_pat(2'd0, 16'h0101);
      write_pat(2'd1, 16'h1010);
      write_pat(2'd3, 16'h0008);
      tick();
      check("idle_trig", 32'(trig_out), 32'd0);
      run = 1'b1;
      tick();
      check("start_strobe", 32'(step_strobe), 32'd1);
      check("start_step", 32'(step_idx), 32'd0);
      check("start_trig", 32'(trig_out), 32'(exp_trig(0)));
      t0   = cyc;
      prev = cyc;
      tick();
      check("strobe_one_cycle", 32'(step_strobe), 32'd0);
      tick();
      tick();
      check("pulse_hi_last", 32'(trig_out[0]), 32'd1);
      tick();
      check("pulse_lo", 32'(trig_out[0]), 32'd0);
      for (int s = 1; s <= 16; s++) begin
         wait_strobe("p20_strobe", at);
         check("p20_interval", 32'(at - prev), 32'd20);
         check("p20_step", 32'(step_idx), 32'(s % 16));
         check("p20_trig", 32'(trig_out), 32'(exp_trig(s % 16)));
         prev = at;
      end
      check("loop_len", 32'(prev - t0), 32'd320);

      // Below-clamp period: spacing becomes 8 from the interval after the next fire
      step_period = 24'd3;
      write_pat(2'd2, 16'hFFFF);
      wait_strobe("clamp_strobe1", at);
      check("clamp_old_interval", 32'(at - prev), 32'd20);
      prev = at;
      wait_strobe("clamp_strobe2", at);
      check("clamp_interval", 32'(at - prev), 32'd8);
      check("clamp_step", 32'(step_idx), 32'd2);
      check("clamp_trig", 32'(trig_out), 32'(exp_trig(2)));
      prev = at;
      tick();
      tick();
      tick();
      check("sq_hi", 32'(trig_out[2]), 32'd1);
      tick();
      check("sq_lo_start", 32'(trig_out[2]), 32'd0);
      tick();
      tick();
      tick();
      check("sq_lo_end", 32'(trig_out[2]), 32'd0);

      // Write on the exact fire edge of step 3: old pattern still fires
      pat_wr_en    = 1'b1;
      pat_wr_voice = 2'd3;
      pat_wr_data  = 16'h0000;
      e            = exp_trig(3);
      tick();
      pat_wr_en = 1'b0;
      pat_m[3]  = 16'h0000;
      check("wrfire_strobe", 32'(step_strobe), 32'd1);
      check("wrfire_interval", 32'(cyc - prev), 32'd8);
      check("wrfire_step", 32'(step_idx), 32'd3);
      check("wrfire_old_bit", 32'(trig_out[3]), 32'd1);
      check("wrfire_trig", 32'(trig_out), 32'(e));
      prev = cyc;
      for (int s = 4; s <= 19; s++) begin
         wait_strobe("p8_strobe", at);
         check("p8_interval", 32'(at - prev), 32'd8);
         check("p8_step", 32'(step_idx), 32'(s % 16));
         check("p8_trig", 32'(trig_out), 32'(exp_trig(s % 16)));
         prev = at;
      end
      check("step3_silent", 32'(trig_out[3]), 32'd0);

      // Stop while voice 0 is high, then restart
      k = 0;
      do begin
         wait_strobe("seek0_strobe", at);
         k++;
      end while (step_idx != 4'd0 && k < 20);
      check("seek0_step", 32'(step_idx), 32'd0);
      tick();
      check("stop_pre_hi", 32'(trig_out[0]), 32'd1);
      run = 1'b0;
      tick();
      check("stop_trig", 32'(trig_out), 32'd0);
      check("stop_step", 32'(step_idx), 32'd0);
      check("stop_strobe", 32'(step_strobe), 32'd0);
      tick();
      check("stopped_trig", 32'(trig_out), 32'd0);
      run = 1'b1;
      tick();
      check("restart_strobe", 32'(step_strobe), 32'd1);
      check("restart_step", 32'(step_idx), 32'd0);
      check("restart_trig", 32'(trig_out), 32'(exp_trig(0)));

      // Asynchronous reset mid-pulse
      tick();
      check("pre_rst_hi", 32'(trig_out[0]), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_trig", 32'(trig_out), 32'd0);
      check("async_rst_step", 32'(step_idx), 32'd0);
      check("async_rst_strobe", 32'(step_strobe), 32'd0);
      run = 1'b0;
      tick();
      rst = 1'b0;
      for (int v = 0; v < 4; v++) pat_m[v] = '0;
      step_period = 24'd8;
      run = 1'b1;
      tick();
      check("postrst_strobe", 32'(step_strobe), 32'd1);
      check("postrst_trig", 32'(trig_out), 32'd0);
      prev = cyc;
      for (int s = 1; s <= 3; s++) begin
         wait_strobe("postrst_strobe_n", at);
         check("postrst_interval", 32'(at - prev), 32'd8);
         check("postrst_trig_n", 32'(trig_out), 32'd0);
         prev = at;
      end

`ifdef DRUM_SEQ_SWING_EN
      // Swing: 26/14 alternation, then a clamped swing gives 32/8
      run = 1'b0;
      tick();
      step_period = 24'd20;
      swing       = 24'd6;
      run         = 1'b1;
      tick();
      check("swing_start", 32'(step_strobe), 32'd1);
      prev = cyc;
      for (int n = 1; n <= 6; n++) begin
         int exp_iv;
         wait_strobe("swing_strobe", at);
         case (n)
            1, 3:    exp_iv = 26;
            2, 4:    exp_iv = 14;
            5:       exp_iv = 32;
            default: exp_iv = 8;
         endcase
         check("swing_interval", 32'(at - prev), 32'(exp_iv));
         prev = at;
         if (n == 3) swing = 24'd50;
      end
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
